controle_jogo: RTL and testbench
================================

Name: controle_jogo

Overview:
- Game-state controller directly downstream of the entities stage.
- Consumes ship position, enemy-ball position/radius and the enemy-alive flag.
- Produces the `pausa` and `reiniciarJogo` signals that drive the entities stage, plus lives, score and state for the HUD/renderer.
- Runs a start/pause FSM, frame-tick-sampled ship-hit detection with invulnerability window, and kill scoring.

Parameters:
- TICK_DIV, 833333, CLOCK_50 cycles per frame tick (60 Hz); bench uses 4
- VIDAS_INICIAIS, 3, lives loaded on restart (1..3)
- LARGURA_NAVE, 45, ship hitbox width in pixels
- ALTURA_NAVE, 20, ship hitbox height in pixels
- INVULN_FRAMES, 60, frame ticks during which hits are ignored after a hit
- PONTOS_INIMIGO, 10, score added per enemy kill

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low reset
- botao_iniciar  in  1  start/pause button level, asynchronous to clock
- x_nave  in  10  ship top-left x
- y_nave  in  10  ship top-left y
- x_bola_inimiga  in  10  enemy ball centre x
- y_bola_inimiga  in  10  enemy ball centre y
- raio_bola_inimiga  in  10  enemy ball radius
- inimigo_vivo  in  1  enemy alive flag
- pausa  out  1  freezes entities when 1
- reiniciarJogo  out  1  one-cycle restart pulse to entities
- vidas  out  2  remaining lives
- pontuacao  out  10  score, binary, saturates at 999
- estado  out  2  FSM state: ESPERA=0, JOGANDO=1, PAUSADO=2, FIM=3
- invulneravel  out  1  invulnerability window active (for ship blink)

Behaviour:
- Reset (reset=0, async) values:
  - estado=ESPERA, pausa=1, reiniciarJogo=0
  - vidas=VIDAS_INICIAIS, pontuacao=0, invulneravel=0
  - tick counter=0, synchroniser and edge registers=0
- Button conditioning: botao_iniciar passes a 2-flop synchroniser and then a rising-edge detector, giving the one-cycle `press`. Latency from input edge to `press` is 3 cycles. Debouncing is upstream.
- Frame tick: counter 0..TICK_DIV-1; `tick` pulses when it wraps. The counter free-runs in all states.
- pausa = 1 in every state except JOGANDO (registered from the state).
- State transitions:
  - ESPERA + press → JOGANDO. Pulse reiniciarJogo for 1 cycle, reload vidas, clear pontuacao and invulnerability.
  - JOGANDO + press → PAUSADO. PAUSADO + press → JOGANDO, no restart.
  - JOGANDO + hit with vidas=1 → FIM, vidas=0.
  - FIM + press → JOGANDO with the same restart actions as ESPERA.
- Hit test (combinational, evaluated only when tick=1 in JOGANDO): box overlap of the ball square with the ship rectangle, all operands zero-extended to 11 bits so sums cannot wrap. Hit when all four hold:
  - xb+r >= xn
  - xb <= xn+LARGURA_NAVE+r
  - yb+r >= yn
  - yb <= yn+ALTURA_NAVE+r
- Hit action when not invulnerable: vidas-1 and load the invulnerability counter with INVULN_FRAMES. Hits during invulnerability are ignored.
- Invulnerability counter: decrements on tick only in JOGANDO, so it is frozen while paused. invulneravel=(counter!=0).
- Kill: falling edge of inimigo_vivo in JOGANDO adds PONTOS_INIMIGO, saturating at 999. Edge detection is masked during the reiniciarJogo cycle and the cycle after it.
- Simultaneous events:
  - press and hit in the same cycle: press wins; hit discarded.
  - Kill and hit on the same cycle: both applied.
  - Kill in PAUSADO/ESPERA/FIM: ignored.
- Reset asserted mid-game returns everything to reset values immediately.

Optional Feature:
- Macro: VIDA_EXTRA_EN.
- When defined: each time pontuacao crosses a multiple of 100 (old/100 != new/100), vidas increments, saturating at 3. When the same cycle has both a hit and a bonus, the hit is applied first and then the bonus; FIM still results if vidas was 1.
- When undefined: vidas only decrements or reloads.

Decomposition:
- Package jogo_pkg:
  - state encodings ESPERA/JOGANDO/PAUSADO/FIM
  - PONTUACAO_MAX=999
  - screen constants 640x480
- Sub-module detector_borda: 2-flop synchroniser plus rising-edge pulse. It is reused for botao_iniciar, and an inverted instance needing no sync handles inimigo_vivo.

Test Plan:
1. Reset, then pulse botao_iniciar → press 3 cycles later; estado 0→1, pausa 1→0, reiniciarJogo high exactly 1 cycle, vidas=3, pontuacao=0.
2. JOGANDO, ship (100,400), ball centre (110,405) r=5, next tick → vidas=2, invulneravel=1. A further overlap for 59 ticks → vidas stays 2; after 60 ticks invulneravel=0 and the next overlap gives vidas=1.
3. Ball at (99,400) r=0 → no hit. Ball (95,400) r=5 → hit. Boundary x=xn+45+r=150 r=5 → hit; x=151 → no hit.
4. vidas=1 plus hit → estado=FIM, vidas=0, pausa=1. press → JOGANDO, vidas=3, pontuacao=0, reiniciarJogo pulse.
5. inimigo_vivo 1→0 in JOGANDO → pontuacao+10. Same edge in PAUSADO → unchanged. pontuacao=995 plus kill → 999.
6. press and hit in the same cycle in JOGANDO → estado=PAUSADO, vidas unchanged. With VIDA_EXTRA_EN, pontuacao 90→100 → vidas+1, capped at 3.

Source files
------------

// File: rtl/jogo_pkg.sv
// jogo_pkg: shared definitions for the game-state controller.
//   - estado_t : FSM state encoding exported on the HUD 'estado' port
//   - PONTUACAO_MAX : score saturation ceiling
//   - LARGURA_TELA / ALTURA_TELA : screen size in pixels
package jogo_pkg;

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    JOGANDO = 2'd1,
    PAUSADO = 2'd2,
    FIM     = 2'd3
  } estado_t;

  localparam int PONTUACAO_MAX = 999;
  localparam int LARGURA_TELA  = 640;
  localparam int ALTURA_TELA   = 480;

endpackage

// File: rtl/detector_borda.sv
// detector_borda: optional 2-flop synchroniser followed by a registered
// rising-edge detector producing a one-cycle pulse.
//   SINCRONIZAR=1 : input is asynchronous, pulse appears 3 cycles after the edge
//   SINCRONIZAR=0 : input is already synchronous, pulse appears 1 cycle after
//   INVERTER=1    : detect the falling edge instead (input is inverted first)
// Ports:
//   clk_i   in  clock
//   rst_n_i in  asynchronous active-low reset
//   sinal_i in  level to watch
//   pulso_o out one-cycle edge pulse
module detector_borda #(
  parameter bit SINCRONIZAR = 1'b1,
  parameter bit INVERTER    = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic sinal_i,
  output logic pulso_o
);

  logic entrada;
  logic nivel;
  logic s1_q, s2_q, ant_q, pulso_q;

  assign entrada = INVERTER ? ~sinal_i : sinal_i;
  assign nivel   = SINCRONIZAR ? s2_q : entrada;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      ant_q   <= 1'b0;
      pulso_q <= 1'b0;
    end else begin
      s1_q    <= entrada;
      s2_q    <= s1_q;
      ant_q   <= nivel;
      pulso_q <= nivel & ~ant_q;
    end
  end

  assign pulso_o = pulso_q;

endmodule

// File: rtl/controle_jogo.sv
// controle_jogo: game-state controller downstream of the entities stage.
// Runs the start/pause FSM, frame-tick sampled ship-hit detection with an
// invulnerability window, kill scoring (saturating at 999) and lives.
// Optional feature macro VIDA_EXTRA_EN: extra life each time the score
// crosses a multiple of 100 (lives saturate at 3).
// Ports:
//   CLOCK_50            in  system clock
//   reset               in  asynchronous active-low reset
//   botao_iniciar       in  start/pause button level (asynchronous)
//   x_nave, y_nave      in  ship top-left corner
//   x_bola_inimiga,
//   y_bola_inimiga      in  enemy ball centre
//   raio_bola_inimiga   in  enemy ball radius
//   inimigo_vivo        in  enemy alive flag
//   pausa               out freezes entities (1 outside JOGANDO)
//   reiniciarJogo       out one-cycle restart pulse
//   vidas               out remaining lives
//   pontuacao           out score
//   estado              out FSM state
//   invulneravel        out invulnerability window active
module controle_jogo
  import jogo_pkg::*;
#(
  parameter int TICK_DIV       = 833333,
  parameter int VIDAS_INICIAIS = 3,
  parameter int LARGURA_NAVE   = 45,
  parameter int ALTURA_NAVE    = 20,
  parameter int INVULN_FRAMES  = 60,
  parameter int PONTOS_INIMIGO = 10
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       botao_iniciar,
  input  logic [9:0] x_nave,
  input  logic [9:0] y_nave,
  input  logic [9:0] x_bola_inimiga,
  input  logic [9:0] y_bola_inimiga,
  input  logic [9:0] raio_bola_inimiga,
  input  logic       inimigo_vivo,
  output logic       pausa,
  output logic       reiniciarJogo,
  output logic [1:0] vidas,
  output logic [9:0] pontuacao,
  output logic [1:0] estado,
  output logic       invulneravel
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = $clog2(INVULN_FRAMES + 1);

  estado_t       estado_q, estado_d;
  logic          pausa_q, reinic_q, reinic_d, mascara_q;
  logic [1:0]    vidas_q, vidas_d;
  logic [9:0]    pontos_q, pontos_d;
  logic [IW-1:0] invuln_q, invuln_d;
  logic [CW-1:0] tick_q;
  logic [10:0]   xn, yn, xb, yb, r, soma;
  logic          press, queda_inimigo, tick, sobrepoe, dano, abate;

  detector_borda #(.SINCRONIZAR(1'b1), .INVERTER(1'b0)) u_botao (
    .clk_i(CLOCK_50), .rst_n_i(reset), .sinal_i(botao_iniciar), .pulso_o(press)
  );

  // inimigo_vivo is already synchronous to CLOCK_50 (entities stage)
  detector_borda #(.SINCRONIZAR(1'b0), .INVERTER(1'b1)) u_inimigo (
    .clk_i(CLOCK_50), .rst_n_i(reset), .sinal_i(inimigo_vivo), .pulso_o(queda_inimigo)
  );

  assign tick = (tick_q == CW'(TICK_DIV - 1));

  // Box overlap of the ball's bounding square against the ship rectangle
  assign xn = {1'b0, x_nave};
  assign yn = {1'b0, y_nave};
  assign xb = {1'b0, x_bola_inimiga};
  assign yb = {1'b0, y_bola_inimiga};
  assign r  = {1'b0, raio_bola_inimiga};
  assign sobrepoe = (xb + r >= xn) && (xb <= xn + 11'(LARGURA_NAVE) + r) &&
                    (yb + r >= yn) && (yb <= yn + 11'(ALTURA_NAVE) + r);

  // A press in the same cycle discards the hit
  assign dano  = tick && (estado_q == JOGANDO) && sobrepoe && !press && (invuln_q == '0);
  // Kill edges are ignored while the entities stage is being restarted
  assign abate = queda_inimigo && (estado_q == JOGANDO) && !reinic_q && !mascara_q;
  assign soma  = 11'(pontos_q) + 11'(PONTOS_INIMIGO);

  // FSM: state register
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) estado_q <= ESPERA;
    else        estado_q <= estado_d;
  end

  // FSM: next state
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      ESPERA, FIM: if (press) estado_d = JOGANDO;
      JOGANDO: begin
        if (press)                          estado_d = PAUSADO;
        else if (dano && vidas_q == 2'd1)   estado_d = FIM;
      end
      PAUSADO: if (press) estado_d = JOGANDO;
      default: estado_d = ESPERA;
    endcase
  end

  // FSM: outputs (restart request)
  always_comb begin
    reinic_d = press && (estado_q == ESPERA || estado_q == FIM);
  end

  // Lives / score / invulnerability next state
  always_comb begin
    vidas_d  = vidas_q;
    pontos_d = pontos_q;
    invuln_d = invuln_q;
    if (reinic_d) begin
      vidas_d  = 2'(VIDAS_INICIAIS);
      pontos_d = '0;
      invuln_d = '0;
    end else begin
      if (abate)
        pontos_d = (soma > 11'(PONTUACAO_MAX)) ? 10'(PONTUACAO_MAX) : soma[9:0];
      if (dano) begin
        vidas_d  = vidas_q - 2'd1;
        invuln_d = IW'(INVULN_FRAMES);
      end else if (tick && estado_q == JOGANDO && invuln_q != '0) begin
        invuln_d = invuln_q - 1'b1;
      end
`ifdef VIDA_EXTRA_EN
      // Bonus applied after the hit; a game-ending hit keeps vidas at 0
      if (abate && (pontos_q / 10'd100 != pontos_d / 10'd100) &&
          vidas_d != 2'd0 && vidas_d != 2'd3)
        vidas_d = vidas_d + 2'd1;
`endif
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      tick_q    <= '0;
      pausa_q   <= 1'b1;
      reinic_q  <= 1'b0;
      mascara_q <= 1'b0;
      vidas_q   <= 2'(VIDAS_INICIAIS);
      pontos_q  <= '0;
      invuln_q  <= '0;
    end else begin
      tick_q    <= tick ? '0 : tick_q + 1'b1;
      pausa_q   <= (estado_d != JOGANDO);
      reinic_q  <= reinic_d;
      mascara_q <= reinic_q;
      vidas_q   <= vidas_d;
      pontos_q  <= pontos_d;
      invuln_q  <= invuln_d;
    end
  end

  assign pausa         = pausa_q;
  assign reiniciarJogo = reinic_q;
  assign vidas         = vidas_q;
  assign pontuacao     = pontos_q;
  assign estado        = estado_q;
  assign invulneravel  = (invuln_q != '0);

endmodule

// File: tb/tb_controle_jogo.sv
// Directed testbench for controle_jogo (TICK_DIV=4). Optional macro
// VIDA_EXTRA_EN changes the expected lives on a 100-point crossing.
module tb_controle_jogo;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       botao;
  logic [9:0] xn, yn, xb, yb, rb;
  logic       vivo;
  logic       pausa, reinic, invuln;
  logic [1:0] vidas, estado;
  logic [9:0] pontos;

  int n_comp = 0;
  int n_erro = 0;
  int fase   = 0;
  bit tick_passou;
  int pont_esp;

  controle_jogo #(
    .TICK_DIV(TD), .VIDAS_INICIAIS(3), .LARGURA_NAVE(45), .ALTURA_NAVE(20),
    .INVULN_FRAMES(60), .PONTOS_INIMIGO(10)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .botao_iniciar(botao),
    .x_nave(xn), .y_nave(yn), .x_bola_inimiga(xb), .y_bola_inimiga(yb),
    .raio_bola_inimiga(rb), .inimigo_vivo(vivo),
    .pausa(pausa), .reiniciarJogo(reinic), .vidas(vidas), .pontuacao(pontos),
    .estado(estado), .invulneravel(invuln)
  );

  always #5 clk = ~clk;

  task automatic verifica(input string tag, input int obs, input int esp);
    n_comp++;
    if (obs != esp) begin
      n_erro++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
    end
  endtask

  // One clock; the bench mirrors the free-running frame counter in 'fase'
  task automatic passo();
    tick_passou = (fase == TD - 1);
    @(posedge clk);
    #1;
    fase = (fase + 1) % TD;
  endtask

  task automatic espera_tick();
    do passo(); while (!tick_passou);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) espera_tick();
  endtask

  task automatic alinha(input int f);
    while (fase != f) passo();
  endtask

  task automatic bola(input int x, input int y, input int r);
    xb = 10'(x); yb = 10'(y); rb = 10'(r);
  endtask

  task automatic bola_longe();
    bola(500, 100, 5);
  endtask

  // Returns right after the edge on which the controller acts on the press
  task automatic aperta();
    botao = 1'b1;
    passo();
    botao = 1'b0;
    passo(); passo(); passo();
  endtask

  // Score is updated on the second edge after the falling edge
  task automatic mata();
    vivo = 1'b0;
    passo(); passo();
    vivo = 1'b1;
    passo();
  endtask

  task automatic aplica_reset();
    reset = 1'b0;
    #1;
    @(posedge clk);
    #2;
    reset = 1'b1;
    fase  = 0;
  endtask

  initial begin
    reset = 1'b0; botao = 1'b0; vivo = 1'b1;
    xn = 10'd100; yn = 10'd400;
    bola_longe();
    aplica_reset();

    // Reset values
    verifica("rst_estado", estado, 0);
    verifica("rst_pausa", pausa, 1);
    verifica("rst_reinic", reinic, 0);
    verifica("rst_vidas", vidas, 3);
    verifica("rst_pontos", pontos, 0);
    verifica("rst_invuln", invuln, 0);

    // Start: press reaches the FSM after 3 edges, acted on at the 4th
    botao = 1'b1;
    passo();
    botao = 1'b0;
    passo(); passo();
    verifica("lat_estado", estado, 0);
    passo();
    verifica("ini_estado", estado, 1);
    verifica("ini_pausa", pausa, 0);
    verifica("ini_reinic", reinic, 1);
    verifica("ini_vidas", vidas, 3);
    verifica("ini_pontos", pontos, 0);
    passo();
    verifica("ini_reinic_fim", reinic, 0);

    // Hit and invulnerability window
    bola(110, 405, 5);
    espera_tick();
    verifica("hit1_vidas", vidas, 2);
    verifica("hit1_inv", invuln, 1);
    ticks(59);
    verifica("inv59_vidas", vidas, 2);
    verifica("inv59_inv", invuln, 1);
    espera_tick();
    verifica("inv60_vidas", vidas, 2);
    verifica("inv60_inv", invuln, 0);

    // Hitbox boundaries
    bola(99, 400, 0);
    espera_tick();
    verifica("x99r0_nohit", vidas, 2);
    bola(151, 400, 5);
    espera_tick();
    verifica("x151_nohit", vidas, 2);
    bola(150, 400, 5);
    espera_tick();
    verifica("x150_hit", vidas, 1);
    verifica("x150_inv", invuln, 1);
    bola_longe();
    ticks(60);
    verifica("inv_off", invuln, 0);

    // Last life lost -> FIM
    bola(95, 400, 5);
    espera_tick();
    verifica("fim_estado", estado, 3);
    verifica("fim_vidas", vidas, 0);
    verifica("fim_pausa", pausa, 1);

    // Restart from FIM
    bola_longe();
    aperta();
    verifica("rei_estado", estado, 1);
    verifica("rei_reinic", reinic, 1);
    verifica("rei_vidas", vidas, 3);
    verifica("rei_pontos", pontos, 0);
    verifica("rei_inv", invuln, 0);
    passo();
    verifica("rei_reinic_fim", reinic, 0);
    passo();

    // Kill scoring, ignored while paused
    mata();
    verifica("kill_pontos", pontos, 10);
    aperta();
    verifica("pausa_estado", estado, 2);
    verifica("pausa_pausa", pausa, 1);
    mata();
    verifica("kill_pausado", pontos, 10);
    aperta();
    verifica("retoma_estado", estado, 1);

    // Press and hit on the same edge: press wins
    alinha(0);
    bola(110, 405, 5);
    botao = 1'b1;
    passo();
    botao = 1'b0;
    passo(); passo(); passo();
    verifica("presshit_estado", estado, 2);
    verifica("presshit_vidas", vidas, 3);
    verifica("presshit_inv", invuln, 0);
    bola_longe();
    aperta();

    // Kill and hit on the same edge: both applied
    alinha(2);
    bola(110, 405, 5);
    vivo = 1'b0;
    passo(); passo();
    verifica("killhit_vidas", vidas, 2);
    verifica("killhit_pontos", pontos, 20);
    verifica("killhit_inv", invuln, 1);
    vivo = 1'b1;
    bola_longe();
    passo();

    // Score saturation
    for (int i = 0; i < 97; i++) mata();
    verifica("pontos_990", pontos, 990);
    mata();
    verifica("pontos_sat", pontos, 999);
    mata();
    verifica("pontos_sat2", pontos, 999);

    // Asynchronous reset mid-game
    reset = 1'b0;
    #1;
    verifica("mrst_estado", estado, 0);
    verifica("mrst_vidas", vidas, 3);
    verifica("mrst_pontos", pontos, 0);
    verifica("mrst_pausa", pausa, 1);
    verifica("mrst_inv", invuln, 0);
    aplica_reset();

    // Crossing a multiple of 100 (extra life only with VIDA_EXTRA_EN)
    aperta();
    passo(); passo();
    alinha(0);
    bola(110, 405, 5);
    espera_tick();
    bola_longe();
    verifica("bonus_pre_vidas", vidas, 2);
    for (int i = 0; i < 9; i++) mata();
    verifica("bonus_90_pontos", pontos, 90);
    verifica("bonus_90_vidas", vidas, 2);
    mata();
    verifica("bonus_100_pontos", pontos, 100);
`ifdef VIDA_EXTRA_EN
    verifica("bonus_100_vidas", vidas, 3);
`else
    verifica("bonus_100_vidas", vidas, 2);
`endif
    pont_esp = 100;
    for (int i = 0; i < 10; i++) begin
      mata();
      pont_esp += 10;
    end
    verifica("bonus_200_pontos", pontos, pont_esp);
`ifdef VIDA_EXTRA_EN
    verifica("bonus_200_vidas", vidas, 3);
`else
    verifica("bonus_200_vidas", vidas, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_erro);
    $finish;
  end

endmodule
